instruction_fetch_unit: RTL and testbench

//  Fetch front end that produces the 32-bit INSTRUCTION word consumed by the decode stage.

---
 rtl/instruction_fetch_unit.sv | 190 +++++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch front end. Holds the PC, issues in-order fetch requests to the
// instruction cache, buffers returned words together with their PCs and
// presents them to decode over a valid/ready handshake. A PC redirect flushes
// the buffer and marks every in-flight fetch as stale so that its response is
// dropped on arrival.
//
// Ports
//   CLK, RST               clock, synchronous active-high reset
//   PC_REDIRECT(_TARGET)   load a new PC (low two bits forced to zero), flush
//   CACHE_REQ_*            fetch request handshake, address = current PC
//   CACHE_RESP_*           returned words, strictly in request order
//   INSTRUCTION(_PC/_VALID) buffer head to decode (NOP_WORD when empty)
//   DECODE_READY           decode consumes the head this cycle
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned           FIFO_DEPTH   = 2,
    parameter logic [31:0]           NOP_WORD     = 32'h0000_0013
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  PC_REDIRECT,
    input  logic [ADDR_WIDTH-1:0] PC_REDIRECT_TARGET,
    output logic                  CACHE_REQ_VALID,
    input  logic                  CACHE_REQ_READY,
    output logic [ADDR_WIDTH-1:0] CACHE_REQ_ADDR,
    input  logic                  CACHE_RESP_VALID,
    input  logic [31:0]           CACHE_RESP_DATA,
    output logic [31:0]           INSTRUCTION,
    output logic [ADDR_WIDTH-1:0] INSTRUCTION_PC,
    output logic                  INSTRUCTION_VALID,
    input  logic                  DECODE_READY
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    // Architectural state
    logic [ADDR_WIDTH-1:0] pc_reg;
    cnt_t                  outstanding;   // requests accepted, response not yet seen
    cnt_t                  discard;       // how many of those are stale (pre-redirect)

    // Instruction buffer: entry 0 is always the head, so decode sees registers directly.
    logic [31:0]           buf_data     [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] buf_pc       [FIFO_DEPTH];
    cnt_t                  buf_count;

    // PCs of live (non-stale) in-flight requests, oldest at entry 0.
    logic [ADDR_WIDTH-1:0] pcq          [FIFO_DEPTH];
    cnt_t                  pcq_count;

    // Next-state values
    logic [ADDR_WIDTH-1:0] pc_nxt;
    cnt_t                  outstanding_nxt;
    cnt_t                  discard_nxt;
    logic [31:0]           buf_data_nxt [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] buf_pc_nxt   [FIFO_DEPTH];
    cnt_t                  buf_count_nxt;
    cnt_t                  buf_wr_idx;
    logic [ADDR_WIDTH-1:0] pcq_nxt      [FIFO_DEPTH];
    cnt_t                  pcq_count_nxt;
    cnt_t                  pcq_wr_idx;

    // Handshake qualifiers
    logic credit_ok;
    logic req_accept;
    logic resp_keep;
    logic dec_pop;
    logic unused_target_bits;

    assign unused_target_bits = ^PC_REDIRECT_TARGET[1:0];

    // Issue only while every accepted request is guaranteed a buffer slot.
    assign credit_ok       = (int'(outstanding) + int'(buf_count)) < int'(FIFO_DEPTH);
    assign CACHE_REQ_VALID = !RST && !PC_REDIRECT && credit_ok;
    assign CACHE_REQ_ADDR  = pc_reg;
    assign req_accept      = CACHE_REQ_VALID && CACHE_REQ_READY;

    // A response arriving during a redirect is stale by definition.
    assign resp_keep = CACHE_RESP_VALID && (discard == '0) && !PC_REDIRECT;
    assign dec_pop   = INSTRUCTION_VALID && DECODE_READY && !PC_REDIRECT;

    assign INSTRUCTION_VALID = (buf_count != '0);
    assign INSTRUCTION       = INSTRUCTION_VALID ? buf_data[0] : NOP_WORD;
    assign INSTRUCTION_PC    = buf_pc[0];

    // PC and in-flight accounting
    always_comb begin
        pc_nxt          = pc_reg;
        outstanding_nxt = outstanding + cnt_t'(req_accept) - cnt_t'(CACHE_RESP_VALID);
        discard_nxt     = discard;

        if (PC_REDIRECT) begin
            pc_nxt      = {PC_REDIRECT_TARGET[ADDR_WIDTH-1:2], 2'b00};
            // Everything still in flight is stale; a response landing now is dropped too.
            discard_nxt = outstanding - cnt_t'(CACHE_RESP_VALID);
        end else begin
            if (req_accept) begin
                pc_nxt = pc_reg + ADDR_WIDTH'(4);
            end
            if (CACHE_RESP_VALID && (discard != '0)) begin
                discard_nxt = discard - cnt_t'(1'b1);
            end
        end
    end

    // In-flight PC queue: shift out on a kept response, append on accept.
    always_comb begin
        pcq_nxt       = pcq;
        pcq_wr_idx    = pcq_count - cnt_t'(resp_keep);
        pcq_count_nxt = pcq_count + cnt_t'(req_accept) - cnt_t'(resp_keep);

        if (resp_keep) begin
            for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) begin
                pcq_nxt[i] = pcq[i+1];
            end
        end
        if (req_accept) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                if (cnt_t'(i) == pcq_wr_idx) begin
                    pcq_nxt[i] = pc_reg;
                end
            end
        end
        if (PC_REDIRECT) begin
            pcq_count_nxt = '0;
        end
    end

    // Instruction buffer: shift on pop, then write the new word just past the
    // surviving entries so a same-cycle push and pop keeps order.
    always_comb begin
        buf_data_nxt  = buf_data;
        buf_pc_nxt    = buf_pc;
        buf_wr_idx    = buf_count - cnt_t'(dec_pop);
        buf_count_nxt = buf_count + cnt_t'(resp_keep) - cnt_t'(dec_pop);

        if (dec_pop) begin
            for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) begin
                buf_data_nxt[i] = buf_data[i+1];
                buf_pc_nxt[i]   = buf_pc[i+1];
            end
        end
        if (resp_keep) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                if (cnt_t'(i) == buf_wr_idx) begin
                    buf_data_nxt[i] = CACHE_RESP_DATA;
                    buf_pc_nxt[i]   = pcq[0];
                end
            end
        end
        if (PC_REDIRECT) begin
            buf_count_nxt = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_reg      <= RESET_VECTOR;
            outstanding <= '0;
            discard     <= '0;
            buf_count   <= '0;
            pcq_count   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                buf_data[i] <= NOP_WORD;
                buf_pc[i]   <= RESET_VECTOR;
                pcq[i]      <= RESET_VECTOR;
            end
        end else begin
            pc_reg      <= pc_nxt;
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;
            buf_count   <= buf_count_nxt;
            pcq_count   <= pcq_count_nxt;
            buf_data    <= buf_data_nxt;
            buf_pc      <= buf_pc_nxt;
            pcq         <= pcq_nxt;
        end
    end

    // A response with nothing outstanding means the cache protocol was broken.
    resp_needs_request: assert property (
        @(posedge CLK) disable iff (RST) CACHE_RESP_VALID |-> (outstanding != '0)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam logic [31:0] KEY = 32'h5A5A_0000;   // returned word = address ^ KEY
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        PC_REDIRECT = 1'b0;
    logic [31:0] PC_REDIRECT_TARGET = '0;
    logic        CACHE_REQ_VALID;
    logic        CACHE_REQ_READY = 1'b1;
    logic [31:0] CACHE_REQ_ADDR;
    logic        CACHE_RESP_VALID = 1'b0;
    logic [31:0] CACHE_RESP_DATA = '0;
    logic [31:0] INSTRUCTION;
    logic [31:0] INSTRUCTION_PC;
    logic        INSTRUCTION_VALID;
    logic        DECODE_READY = 1'b0;

    int checks = 0;
    int errors = 0;

    // Cache model state
    logic [31:0] mq[$];
    bit          resp_en = 1'b1;
    bit          last_acc;
    logic [31:0] last_addr;

    instruction_fetch_unit #(
        .ADDR_WIDTH   (32),
        .RESET_VECTOR (32'h0000_0000),
        .FIFO_DEPTH   (2),
        .NOP_WORD     (32'h0000_0013)
    ) dut (
        .CLK                (CLK),
        .RST                (RST),
        .PC_REDIRECT        (PC_REDIRECT),
        .PC_REDIRECT_TARGET (PC_REDIRECT_TARGET),
        .CACHE_REQ_VALID    (CACHE_REQ_VALID),
        .CACHE_REQ_READY    (CACHE_REQ_READY),
        .CACHE_REQ_ADDR     (CACHE_REQ_ADDR),
        .CACHE_RESP_VALID   (CACHE_RESP_VALID),
        .CACHE_RESP_DATA    (CACHE_RESP_DATA),
        .INSTRUCTION        (INSTRUCTION),
        .INSTRUCTION_PC     (INSTRUCTION_PC),
        .INSTRUCTION_VALID  (INSTRUCTION_VALID),
        .DECODE_READY       (DECODE_READY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: sample the request handshake mid-cycle, then after the edge
    // let the 1-cycle-latency cache model drive the next response.
    task automatic tick();
        logic [31:0] a;
        @(negedge CLK);
        last_acc  = CACHE_REQ_VALID && CACHE_REQ_READY;
        last_addr = CACHE_REQ_ADDR;
        @(posedge CLK);
        #1;
        if (RST) begin
            mq.delete();
            CACHE_RESP_VALID = 1'b0;
        end else begin
            if (last_acc) mq.push_back(last_addr);
            if (resp_en && mq.size() > 0) begin
                a = mq.pop_front();
                CACHE_RESP_VALID = 1'b1;
                CACHE_RESP_DATA  = a ^ KEY;
            end else begin
                CACHE_RESP_VALID = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        PC_REDIRECT = 1'b0;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        DECODE_READY = 1'b1;
        resp_en = 1'b1;
        tick();
        tick();
        checks++; if (INSTRUCTION_VALID !== 1'b0) begin errors++; $display("FAIL reset_ivalid got %0b exp 0", INSTRUCTION_VALID); end
        checks++; if (INSTRUCTION !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", INSTRUCTION, NOP); end
        checks++; if (INSTRUCTION_PC !== 32'h0) begin errors++; $display("FAIL reset_ipc got %h exp 00000000", INSTRUCTION_PC); end
        checks++; if (CACHE_REQ_VALID !== 1'b0) begin errors++; $display("FAIL reset_reqvalid got %0b exp 0", CACHE_REQ_VALID); end
        checks++; if (CACHE_REQ_ADDR !== 32'h0) begin errors++; $display("FAIL reset_reqaddr got %h exp 00000000", CACHE_REQ_ADDR); end
        RST = 1'b0;
        tick();
        checks++; if (last_acc !== 1'b1 || last_addr !== 32'h0) begin errors++; $display("FAIL reset_first_req got acc=%0b addr=%h exp acc=1 addr=00000000", last_acc, last_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        logic [31:0] exp_req;
        int words;
        do_reset();
        DECODE_READY = 1'b1;
        resp_en = 1'b1;
        exp_pc = '0;
        exp_req = '0;
        words = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (last_acc) begin
                checks++; if (last_addr !== exp_req) begin errors++; $display("FAIL stream_req_addr got %h exp %h", last_addr, exp_req); end
                exp_req = exp_req + 32'd4;
            end
            if (INSTRUCTION_VALID) begin
                checks++;
                if (INSTRUCTION_PC !== exp_pc || INSTRUCTION !== (exp_pc ^ KEY)) begin
                    errors++; $display("FAIL stream_word got pc=%h instr=%h exp pc=%h instr=%h", INSTRUCTION_PC, INSTRUCTION, exp_pc, exp_pc ^ KEY);
                end
                exp_pc = exp_pc + 32'd4;
                words++;
            end
        end
        checks++; if (words !== 8) begin errors++; $display("FAIL stream_word_count got %0d exp 8", words); end
        checks++; if (exp_req !== 32'd32) begin errors++; $display("FAIL stream_req_count got %0d exp 8", exp_req / 4); end
    endtask

    task automatic test_backpressure();
        do_reset();
        DECODE_READY = 1'b0;
        resp_en = 1'b1;
        tick(); tick(); tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (INSTRUCTION_VALID !== 1'b1 || INSTRUCTION_PC !== 32'h0 || INSTRUCTION !== (32'h0 ^ KEY)) begin
                errors++; $display("FAIL bp_hold got v=%0b pc=%h instr=%h exp v=1 pc=00000000 instr=%h", INSTRUCTION_VALID, INSTRUCTION_PC, INSTRUCTION, KEY);
            end
            checks++; if (CACHE_REQ_VALID !== 1'b0 || CACHE_REQ_ADDR !== 32'h8) begin
                errors++; $display("FAIL bp_credit got reqv=%0b addr=%h exp reqv=0 addr=00000008", CACHE_REQ_VALID, CACHE_REQ_ADDR);
            end
            tick();
            checks++; if (last_acc !== 1'b0) begin errors++; $display("FAIL bp_no_issue got acc=%0b exp 0", last_acc); end
        end
        DECODE_READY = 1'b1;
        tick();
        checks++; if (INSTRUCTION_PC !== 32'h4 || INSTRUCTION !== (32'h4 ^ KEY)) begin
            errors++; $display("FAIL bp_second got pc=%h instr=%h exp pc=00000004 instr=%h", INSTRUCTION_PC, INSTRUCTION, 32'h4 ^ KEY);
        end
        checks++; if (CACHE_REQ_VALID !== 1'b1) begin errors++; $display("FAIL bp_resume_valid got %0b exp 1", CACHE_REQ_VALID); end
        tick();
        checks++; if (last_acc !== 1'b1 || last_addr !== 32'h8) begin errors++; $display("FAIL bp_resume_addr got acc=%0b addr=%h exp acc=1 addr=00000008", last_acc, last_addr); end
        checks++; if (INSTRUCTION_VALID !== 1'b0) begin errors++; $display("FAIL bp_drained got %0b exp 0", INSTRUCTION_VALID); end
        tick();
        checks++; if (INSTRUCTION_VALID !== 1'b1 || INSTRUCTION_PC !== 32'h8) begin
            errors++; $display("FAIL bp_third got v=%0b pc=%h exp v=1 pc=00000008", INSTRUCTION_VALID, INSTRUCTION_PC);
        end
    endtask

    task automatic test_redirect_inflight();
        bit seen_acc;
        bit seen_word;
        do_reset();
        DECODE_READY = 1'b1;
        resp_en = 1'b0;
        PC_REDIRECT = 1'b1;
        PC_REDIRECT_TARGET = 32'h10;
        tick();
        PC_REDIRECT = 1'b0;
        tick();
        checks++; if (last_acc !== 1'b1 || last_addr !== 32'h10) begin errors++; $display("FAIL rd_req0 got acc=%0b addr=%h exp acc=1 addr=00000010", last_acc, last_addr); end
        tick();
        checks++; if (last_acc !== 1'b1 || last_addr !== 32'h14) begin errors++; $display("FAIL rd_req1 got acc=%0b addr=%h exp acc=1 addr=00000014", last_acc, last_addr); end
        checks++; if (CACHE_REQ_VALID !== 1'b0) begin errors++; $display("FAIL rd_two_inflight got reqv=%0b exp 0", CACHE_REQ_VALID); end
        PC_REDIRECT = 1'b1;
        PC_REDIRECT_TARGET = 32'h103;
        tick();
        checks++; if (CACHE_REQ_ADDR !== 32'h100) begin errors++; $display("FAIL rd_target got %h exp 00000100", CACHE_REQ_ADDR); end
        checks++; if (INSTRUCTION_VALID !== 1'b0) begin errors++; $display("FAIL rd_flushed got %0b exp 0", INSTRUCTION_VALID); end
        PC_REDIRECT = 1'b0;
        resp_en = 1'b1;
        seen_acc = 1'b0;
        seen_word = 1'b0;
        for (int c = 0; c < 10 && !seen_word; c++) begin
            tick();
            if (last_acc && !seen_acc) begin
                seen_acc = 1'b1;
                checks++; if (last_addr !== 32'h100) begin errors++; $display("FAIL rd_first_req got %h exp 00000100", last_addr); end
            end
            if (INSTRUCTION_VALID) begin
                seen_word = 1'b1;
                checks++; if (INSTRUCTION_PC !== 32'h100 || INSTRUCTION !== (32'h100 ^ KEY)) begin
                    errors++; $display("FAIL rd_first_word got pc=%h instr=%h exp pc=00000100 instr=%h", INSTRUCTION_PC, INSTRUCTION, 32'h100 ^ KEY);
                end
            end
        end
        if (!seen_word) begin
            checks++; errors++; $display("FAIL rd_timeout got no valid word exp pc=00000100");
        end
    endtask

    task automatic test_redirect_with_resp();
        do_reset();
        DECODE_READY = 1'b1;
        resp_en = 1'b1;
        tick();
        // response for PC 0 is on the bus during the redirect cycle
        PC_REDIRECT = 1'b1;
        PC_REDIRECT_TARGET = 32'h40;
        tick();
        checks++; if (INSTRUCTION_VALID !== 1'b0) begin errors++; $display("FAIL rr_dropped got %0b exp 0", INSTRUCTION_VALID); end
        checks++; if (CACHE_REQ_ADDR !== 32'h40 || last_acc !== 1'b0) begin errors++; $display("FAIL rr_target got addr=%h acc=%0b exp addr=00000040 acc=0", CACHE_REQ_ADDR, last_acc); end
        PC_REDIRECT = 1'b0;
        tick();
        checks++; if (last_acc !== 1'b1 || last_addr !== 32'h40) begin errors++; $display("FAIL rr_req got acc=%0b addr=%h exp acc=1 addr=00000040", last_acc, last_addr); end
        tick();
        checks++; if (INSTRUCTION_VALID !== 1'b1 || INSTRUCTION_PC !== 32'h40 || INSTRUCTION !== (32'h40 ^ KEY)) begin
            errors++; $display("FAIL rr_word got v=%0b pc=%h instr=%h exp v=1 pc=00000040 instr=%h", INSTRUCTION_VALID, INSTRUCTION_PC, INSTRUCTION, 32'h40 ^ KEY);
        end
        tick();
        checks++; if (INSTRUCTION_VALID !== 1'b1 || INSTRUCTION_PC !== 32'h44) begin
            errors++; $display("FAIL rr_next got v=%0b pc=%h exp v=1 pc=00000044", INSTRUCTION_VALID, INSTRUCTION_PC);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        DECODE_READY = 1'b1;
        resp_en = 1'b1;
        PC_REDIRECT = 1'b1;
        PC_REDIRECT_TARGET = 32'hFFFF_FFFE;
        tick();
        checks++; if (CACHE_REQ_ADDR !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target got %h exp fffffffc", CACHE_REQ_ADDR); end
        PC_REDIRECT = 1'b0;
        tick();
        checks++; if (last_acc !== 1'b1 || last_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req0 got acc=%0b addr=%h exp acc=1 addr=fffffffc", last_acc, last_addr); end
        tick();
        checks++; if (last_acc !== 1'b1 || last_addr !== 32'h0) begin errors++; $display("FAIL wrap_req1 got acc=%0b addr=%h exp acc=1 addr=00000000", last_acc, last_addr); end
        checks++; if (INSTRUCTION_PC !== 32'hFFFF_FFFC || INSTRUCTION !== 32'hA5A5_FFFC) begin
            errors++; $display("FAIL wrap_word0 got pc=%h instr=%h exp pc=fffffffc instr=a5a5fffc", INSTRUCTION_PC, INSTRUCTION);
        end
        checks++; if (CACHE_REQ_ADDR !== 32'h4) begin errors++; $display("FAIL wrap_pc got %h exp 00000004", CACHE_REQ_ADDR); end
        tick();
        checks++; if (INSTRUCTION_VALID !== 1'b1 || INSTRUCTION_PC !== 32'h0 || INSTRUCTION !== KEY) begin
            errors++; $display("FAIL wrap_word1 got v=%0b pc=%h instr=%h exp v=1 pc=00000000 instr=%h", INSTRUCTION_VALID, INSTRUCTION_PC, INSTRUCTION, KEY);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        DECODE_READY = 1'b0;
        resp_en = 1'b1;
        tick(); tick(); tick();
        checks++; if (INSTRUCTION_VALID !== 1'b1 || CACHE_REQ_VALID !== 1'b0) begin
            errors++; $display("FAIL rm_full got v=%0b reqv=%0b exp v=1 reqv=0", INSTRUCTION_VALID, CACHE_REQ_VALID);
        end
        RST = 1'b1;
        tick();
        checks++; if (INSTRUCTION_VALID !== 1'b0 || CACHE_REQ_VALID !== 1'b0) begin
            errors++; $display("FAIL rm_valids got v=%0b reqv=%0b exp v=0 reqv=0", INSTRUCTION_VALID, CACHE_REQ_VALID);
        end
        checks++; if (INSTRUCTION !== NOP) begin errors++; $display("FAIL rm_instr got %h exp %h", INSTRUCTION, NOP); end
        checks++; if (CACHE_REQ_ADDR !== 32'h0) begin errors++; $display("FAIL rm_addr got %h exp 00000000", CACHE_REQ_ADDR); end
        RST = 1'b0;
        tick();
        checks++; if (last_acc !== 1'b1 || last_addr !== 32'h0) begin errors++; $display("FAIL rm_restart got acc=%0b addr=%h exp acc=1 addr=00000000", last_acc, last_addr); end
        tick();
        checks++; if (INSTRUCTION_VALID !== 1'b1 || INSTRUCTION_PC !== 32'h0 || INSTRUCTION !== KEY) begin
            errors++; $display("FAIL rm_word got v=%0b pc=%h instr=%h exp v=1 pc=00000000 instr=%h", INSTRUCTION_VALID, INSTRUCTION_PC, INSTRUCTION, KEY);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_with_resp();
        test_wrap();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
